// File: rtl/flow_pkg.sv
// flow_pkg: constants and types shared by flow_tick_gen, its button
// conditioners and the downstream LED shifter.
//   SPEED_W / SPEED_MAX : width and ceiling of the speed level
//   DIR_LEFT / DIR_RIGHT: shift direction encoding (0x01 -> 0x80 is LEFT)
//   btn_evt_t           : one-cycle press events, one bit per button
package flow_pkg;

  localparam int                  SPEED_W   = 2;
  localparam logic [SPEED_W-1:0]  SPEED_MAX = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int NUM_BTNS = 4;

  // Bit order matches the raw button vector built in the top:
  // faster is the MSB, dir the LSB.
  typedef struct packed {
    logic faster;
    logic slower;
    logic pause;
    logic dir;
  } btn_evt_t;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: conditions one raw asynchronous push-button.
//   clock, reset : system clock, synchronous active-high reset
//   btn_raw      : raw button level, active-high, asynchronous
//   press        : one-cycle registered pulse per accepted rising edge
// A level is accepted only after the synchronised input has differed from
// the accepted level for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] stab_q,  stab_d;
  logic          level_q, level_d;
  logic          level_dly_q, level_dly_d;
  logic          press_q, press_d;

  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    level_d     = level_q;
    stab_d      = stab_q;
    // Any cycle where the input agrees with the accepted level restarts
    // the stability window, so short glitches never accumulate.
    if (sync2_q == level_q) begin
      stab_d = '0;
    end else if (stab_q == CNT_LAST) begin
      level_d = ~level_q;
      stab_d  = '0;
    end else begin
      stab_d = stab_q + CW'(1);
    end
    level_dly_d = level_q;
    press_d     = level_q & ~level_dly_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      stab_q      <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stab_q      <= stab_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/flow_tick_gen.sv
// flow_tick_gen: button-controlled step-rate generator for the LED shifter.
//   clock, reset           : system clock, synchronous active-high reset
//   btn_faster/btn_slower  : raw buttons, step speed up / down (saturating)
//   btn_pause, btn_dir     : raw buttons, toggle paused / direction
//   tick                   : one-cycle step strobe every BASE_PERIOD>>speed
//   dir, paused, speed     : registered state for the shifter and status LEDs
module flow_tick_gen
  import flow_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BASE_PERIOD     = 16_777_216,
  parameter int CNT_W           = 24
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               btn_faster,
  input  logic               btn_slower,
  input  logic               btn_pause,
  input  logic               btn_dir,
  output logic               tick,
  output logic               dir,
  output logic               paused,
  output logic [SPEED_W-1:0] speed
);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] evt_vec;
  btn_evt_t            evt;

  assign btn_raw = {btn_faster, btn_slower, btn_pause, btn_dir};
  assign evt     = btn_evt_t'(evt_vec);

  for (genvar g = 0; g < NUM_BTNS; g++) begin : gen_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clock   (clock),
      .reset   (reset),
      .btn_raw (btn_raw[g]),
      .press   (evt_vec[g])
    );
  end

  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               paused_q, paused_d;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic [CNT_W-1:0]   last_cnt;

  // Terminal count for the current speed (period = BASE_PERIOD >> speed).
  always_comb begin
    case (speed_q)
      2'd0:    last_cnt = CNT_W'(BASE_PERIOD - 1);
      2'd1:    last_cnt = CNT_W'(BASE_PERIOD / 2 - 1);
      2'd2:    last_cnt = CNT_W'(BASE_PERIOD / 4 - 1);
      default: last_cnt = CNT_W'(BASE_PERIOD / 8 - 1);
    endcase
  end

  always_comb begin
    speed_d = speed_q;
    // Opposing events in the same cycle cancel; saturated presses are no-ops.
    if (evt.faster && !evt.slower && speed_q != SPEED_MAX)
      speed_d = speed_q + SPEED_W'(1);
    else if (evt.slower && !evt.faster && speed_q != '0)
      speed_d = speed_q - SPEED_W'(1);

    paused_d = paused_q ^ evt.pause;
    dir_d    = dir_q ^ evt.dir;

    // Counting uses the registered paused value, so a pause event still
    // lets a tick due on the same edge fire.
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (speed_d != speed_q) begin
      cnt_d = '0;
    end else if (!paused_q) begin
      if (cnt_q == last_cnt) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      speed_q  <= '0;
      paused_q <= 1'b0;
      dir_q    <= DIR_LEFT;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      speed_q  <= speed_d;
      paused_q <= paused_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
    end
  end

  assign tick   = tick_q;
  assign dir    = dir_q;
  assign paused = paused_q;
  assign speed  = speed_q;

endmodule
